mem_port_arbiter: RTL and testbench

- Shares one single-outstanding external memory port between the CPU instruction fetch interface (imem_*) and the data load/store interface (dmem_*).
- Grants one requester at a time. dmem has fixed priority; an anti-starvation limit protects imem.
- A watchdog aborts memory accesses that never complete and records a sticky bus error.
- Sits between cpu_top and the external memory controller, inside the CPU AXI wrapper.

---
 rtl/cpu_mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_watchdog.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package cpu_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IMEM = 2'd1,
    ARB_DMEM = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_t;

  // Data returned to the owner when an access is aborted by the watchdog.
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts consecutive cycles of an outstanding memory request and pulses
// timeout when the count reaches TIMEOUT_CYCLES without an acknowledge.
// The first cycle of mem_req counts as 1.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ack,
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: advance while the request waits, restart when it ends.
  always_comb begin
    cnt_d   = '0;
    timeout = 1'b0;
    if (mem_req && !mem_ack) begin
      cnt_d = cnt_q + CW'(1);
      // cnt_q holds the cycles already waited, so this cycle is cnt_q + 1.
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-outstanding memory port between instruction fetch and
// data load/store. dmem has fixed priority, bounded by a starvation limit
// that guarantees imem a grant; a watchdog aborts accesses that never ack.
module mem_port_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int INST_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic                    imem_read,
  output logic [INST_WIDTH-1:0]   imem_read_data,
  output logic                    imem_ready,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_write_data,
  input  logic                    dmem_read,
  input  logic                    dmem_write,
  input  logic [DATA_WIDTH/8-1:0] dmem_byte_enable,
  output logic [DATA_WIDTH-1:0]   dmem_read_data,
  output logic                    dmem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  input  logic                    err_clear,
  output logic                    bus_error,
  output logic [ADDR_WIDTH-1:0]   error_addr,
  output logic [1:0]              grant_owner
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_t            state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  bus_error_q, bus_error_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BW-1:0]         be_q, be_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic busy;
  logic dmem_req;
  logic timeout;

  assign busy     = (state_q == ARB_IMEM) || (state_q == ARB_DMEM);
  assign dmem_req = dmem_read || dmem_write;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .mem_req(busy),
    .mem_ack(mem_ack),
    .timeout(timeout)
  );

  // Next-state, grant, starvation and error bookkeeping.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    bus_error_d = bus_error_q && !err_clear;
    err_addr_d  = err_addr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    we_d        = we_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        owner_d = OWN_NONE;
        if (!imem_read) begin
          starve_d = '0;
        end
        if (imem_read && (!dmem_req || starve_q == SW'(STARVE_LIMIT))) begin
          owner_d  = OWN_IMEM;
          addr_d   = imem_addr;
          wdata_d  = '0;
          be_d     = '1;
          we_d     = 1'b0;
          starve_d = '0;
          state_d  = ARB_IMEM;
        end else if (dmem_req) begin
          owner_d = OWN_DMEM;
          addr_d  = dmem_addr;
          wdata_d = dmem_write_data;
          // A simultaneous read and write is treated as a write.
          we_d    = dmem_write;
          be_d    = dmem_write ? dmem_byte_enable : '1;
          if (imem_read && starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
          end
          // A store with no lanes enabled has nothing to send to memory.
          if (dmem_write && dmem_byte_enable == '0) begin
            rdata_d = '0;
            state_d = ARB_RESP;
          end else begin
            state_d = ARB_DMEM;
          end
        end
      end
      ARB_IMEM, ARB_DMEM: begin
        // A real acknowledge beats a coincident timeout.
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = ARB_RESP;
        end else if (timeout) begin
          rdata_d     = DATA_WIDTH'(BUS_ERR_DATA);
          bus_error_d = 1'b1;
          if (!bus_error_q) begin
            err_addr_d = addr_q;
          end
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Control state is reset; latched request/response data is not, since
  // every output that exposes it is gated by the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      bus_error_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      bus_error_q <= bus_error_d;
      err_addr_q  <= err_addr_d;
    end
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    we_q    <= we_d;
    rdata_q <= rdata_d;
  end

  assign mem_req        = busy;
  assign mem_we         = busy && we_q;
  assign mem_addr       = busy ? addr_q : '0;
  assign mem_wdata      = busy ? wdata_q : '0;
  assign mem_be         = busy ? be_q : '0;
  assign imem_ready     = (state_q == ARB_RESP) && (owner_q == OWN_IMEM);
  assign dmem_ready     = (state_q == ARB_RESP) && (owner_q == OWN_DMEM);
  assign imem_read_data = imem_ready ? rdata_q : '0;
  assign dmem_read_data = dmem_ready ? rdata_q : '0;
  assign bus_error      = bus_error_q;
  assign error_addr     = err_addr_q;
  assign grant_owner    = (state_q == ARB_IDLE) ? OWN_NONE : owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a memory responder, an output
// monitor and a per-scenario sequence with expected-data queues.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr = '0;
  logic          imem_read = 1'b0;
  logic [DW-1:0] imem_read_data;
  logic          imem_ready;
  logic [AW-1:0] dmem_addr = '0;
  logic [DW-1:0] dmem_write_data = '0;
  logic          dmem_read = 1'b0;
  logic          dmem_write = 1'b0;
  logic [BW-1:0] dmem_byte_enable = '0;
  logic [DW-1:0] dmem_read_data;
  logic          dmem_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack;
  logic          resp_ack = 1'b0;
  logic          tb_ack = 1'b0;
  logic          err_clear = 1'b0;
  logic          bus_error;
  logic [AW-1:0] error_addr;
  logic [1:0]    grant_owner;

  assign mem_ack = resp_ack | tb_ack;

  int checks = 0;
  int failures = 0;

  int   resp_lat = 2;
  int   req_age = 0;
  int   imem_pulses = 0;
  int   dmem_pulses = 0;
  int   req_cycles = 0;
  logic prev_req = 1'b0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } grant_t;

  grant_t        glog[$];
  logic [DW-1:0] exp_imem_q[$];
  logic [DW-1:0] exp_dmem_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .INST_WIDTH    (DW),
    .STARVE_LIMIT  (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_read       (imem_read),
    .imem_read_data  (imem_read_data),
    .imem_ready      (imem_ready),
    .dmem_addr       (dmem_addr),
    .dmem_write_data (dmem_write_data),
    .dmem_read       (dmem_read),
    .dmem_write      (dmem_write),
    .dmem_byte_enable(dmem_byte_enable),
    .dmem_read_data  (dmem_read_data),
    .dmem_ready      (dmem_ready),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_be          (mem_be),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack),
    .err_clear       (err_clear),
    .bus_error       (bus_error),
    .error_addr      (error_addr),
    .grant_owner     (grant_owner)
  );

  // Memory contents seen by the responder.
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [DW-1:0] pop_exp(input bit is_d);
    logic [DW-1:0] v;
    v = 32'hBAD0_BAD0;
    if (is_d) begin
      if (exp_dmem_q.size() > 0) v = exp_dmem_q.pop_front();
    end else begin
      if (exp_imem_q.size() > 0) v = exp_imem_q.pop_front();
    end
    return v;
  endfunction

  // Memory responder: ack resp_lat cycles after mem_req first rises (0 = never).
  always @(negedge clk) begin
    resp_ack = 1'b0;
    if (mem_req && resp_lat != 0) begin
      req_age = req_age + 1;
      if (req_age == resp_lat + 1) begin
        resp_ack  = 1'b1;
        mem_rdata = data_of(mem_addr);
      end
    end else begin
      req_age = 0;
    end
  end

  // Output monitor: ready pulses, request cycles and issued accesses.
  always begin
    @(posedge clk);
    #2;
    if (imem_ready) imem_pulses = imem_pulses + 1;
    if (dmem_ready) dmem_pulses = dmem_pulses + 1;
    if (mem_req) req_cycles = req_cycles + 1;
    if (mem_req && !prev_req) glog.push_back({mem_addr, mem_we, mem_be, mem_wdata});
    prev_req = mem_req;
  end

  // Bounded wait for the next ready pulse; which = 0 when none arrived.
  task automatic wait_any(input int limit, output int which, output logic [DW-1:0] data,
                          output int cyc);
    bit done;
    done  = 1'b0;
    which = 0;
    data  = '0;
    cyc   = 0;
    for (int i = 1; i <= limit && !done; i++) begin
      @(negedge clk);
      if (imem_ready) begin
        which = 1; data = imem_read_data; cyc = i; done = 1'b1;
      end else if (dmem_ready) begin
        which = 2; data = dmem_read_data; cyc = i; done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, imem_ready, dmem_ready, bus_error} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 00000",
               {mem_req, mem_we, imem_ready, dmem_ready, bus_error});
    end
    checks++;
    if (mem_addr !== '0 || mem_be !== '0 || error_addr !== '0) begin
      failures++;
      $display("FAIL reset_mem_bus: addr=%h be=%h err_addr=%h want 0", mem_addr, mem_be, error_addr);
    end
    checks++;
    if (imem_read_data !== '0 || dmem_read_data !== '0) begin
      failures++;
      $display("FAIL reset_rdata: imem=%h dmem=%h want 0", imem_read_data, dmem_read_data);
    end
    checks++;
    if (grant_owner !== 2'd0) begin
      failures++;
      $display("FAIL reset_owner: got %0d want 0", grant_owner);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lone_fetch();
    int which, cyc, p_i, p_d, rc;
    logic [DW-1:0] data, exp;
    grant_t g;
    p_i = imem_pulses; p_d = dmem_pulses; rc = req_cycles;
    glog.delete();
    resp_lat = 2;
    exp_imem_q.push_back(32'h0000_0013);
    imem_addr = 32'h100;
    imem_read = 1'b1;
    wait_any(20, which, data, cyc);
    imem_read = 1'b0;
    // grant edge, three request cycles, then the ready cycle
    checks++;
    if (which != 1 || cyc != 4) begin
      failures++;
      $display("FAIL fetch_ready: which=%0d cyc=%0d want 1/4", which, cyc);
    end
    exp = pop_exp(1'b0);
    checks++;
    if (data !== exp) begin
      failures++;
      $display("FAIL fetch_data: got %h want %h", data, exp);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (req_cycles - rc != 3) begin
      failures++;
      $display("FAIL fetch_req_len: got %0d want 3", req_cycles - rc);
    end
    g = (glog.size() > 0) ? glog.pop_front() : '0;
    checks++;
    if (g.addr !== 32'h100 || g.we !== 1'b0 || g.be !== 4'hF) begin
      failures++;
      $display("FAIL fetch_bus: addr=%h we=%b be=%h want 100/0/f", g.addr, g.we, g.be);
    end
    checks++;
    if (imem_pulses - p_i != 1 || dmem_pulses - p_d != 0) begin
      failures++;
      $display("FAIL fetch_pulses: imem=%0d dmem=%0d want 1/0", imem_pulses - p_i, dmem_pulses - p_d);
    end
  endtask

  task automatic test_contention();
    int which, cyc, p_i, p_d;
    logic [DW-1:0] data, exp;
    grant_t g0, g1;
    p_i = imem_pulses; p_d = dmem_pulses;
    glog.delete();
    exp_dmem_q.push_back(data_of(32'h2000));
    exp_imem_q.push_back(32'h0000_0013);
    imem_addr = 32'h100;  imem_read = 1'b1;
    dmem_addr = 32'h2000; dmem_read = 1'b1;
    wait_any(20, which, data, cyc);
    dmem_read = 1'b0;
    exp = pop_exp(1'b1);
    checks++;
    if (which != 2 || data !== exp) begin
      failures++;
      $display("FAIL contend_first: which=%0d data=%h want 2/%h", which, data, exp);
    end
    wait_any(20, which, data, cyc);
    imem_read = 1'b0;
    exp = pop_exp(1'b0);
    checks++;
    if (which != 1 || data !== exp) begin
      failures++;
      $display("FAIL contend_second: which=%0d data=%h want 1/%h", which, data, exp);
    end
    repeat (3) @(negedge clk);
    g0 = (glog.size() > 0) ? glog.pop_front() : '0;
    g1 = (glog.size() > 0) ? glog.pop_front() : '0;
    checks++;
    if (g0.addr !== 32'h2000 || g1.addr !== 32'h100) begin
      failures++;
      $display("FAIL contend_order: got %h,%h want 2000,100", g0.addr, g1.addr);
    end
    checks++;
    if (imem_pulses - p_i != 1 || dmem_pulses - p_d != 1) begin
      failures++;
      $display("FAIL contend_pulses: imem=%0d dmem=%0d want 1/1", imem_pulses - p_i, dmem_pulses - p_d);
    end
  endtask

  task automatic test_starvation();
    int which, cyc, nd;
    logic [DW-1:0] data, exp;
    logic [AW-1:0] order [4];
    grant_t g;
    order[0] = 32'h2000; order[1] = 32'h2004; order[2] = 32'h100; order[3] = 32'h2008;
    glog.delete();
    exp_dmem_q.push_back(data_of(32'h2000));
    exp_dmem_q.push_back(data_of(32'h2004));
    exp_dmem_q.push_back(data_of(32'h2008));
    exp_imem_q.push_back(32'h0000_0013);
    nd = 0;
    imem_addr = 32'h100;  imem_read = 1'b1;
    dmem_addr = 32'h2000; dmem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_any(30, which, data, cyc);
      exp = pop_exp(which == 2);
      checks++;
      if (which == 0 || data !== exp) begin
        failures++;
        $display("FAIL starve_data%0d: which=%0d data=%h want %h", k, which, data, exp);
        break;
      end
      if (which == 2) begin
        nd++;
        if (nd == 3) dmem_read = 1'b0;
        else dmem_addr = dmem_addr + 32'd4;
      end else begin
        imem_read = 1'b0;
      end
    end
    imem_read = 1'b0;
    dmem_read = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      g = (glog.size() > 0) ? glog.pop_front() : '0;
      checks++;
      if (g.addr !== order[k]) begin
        failures++;
        $display("FAIL starve_order%0d: got %h want %h", k, g.addr, order[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int which, cyc, rc;
    logic [DW-1:0] data, exp;
    resp_lat = 0;
    checks++;
    if (bus_error !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pre_err: got %b want 0", bus_error);
    end
    rc = req_cycles;
    exp_dmem_q.push_back(32'hDEADBEEF);
    dmem_addr = 32'h3000; dmem_read = 1'b1;
    wait_any(30, which, data, cyc);
    dmem_read = 1'b0;
    exp = pop_exp(1'b1);
    checks++;
    if (which != 2 || cyc != 9 || data !== exp) begin
      failures++;
      $display("FAIL timeout_resp: which=%0d cyc=%0d data=%h want 2/9/%h", which, cyc, data, exp);
    end
    checks++;
    if (bus_error !== 1'b1 || error_addr !== 32'h3000) begin
      failures++;
      $display("FAIL timeout_err: err=%b addr=%h want 1/3000", bus_error, error_addr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (req_cycles - rc != 8) begin
      failures++;
      $display("FAIL timeout_req_len: got %0d want 8", req_cycles - rc);
    end
    exp_dmem_q.push_back(32'hDEADBEEF);
    dmem_addr = 32'h4000; dmem_read = 1'b1;
    wait_any(30, which, data, cyc);
    dmem_read = 1'b0;
    exp = pop_exp(1'b1);
    checks++;
    if (which != 2 || data !== exp) begin
      failures++;
      $display("FAIL timeout2_resp: which=%0d data=%h want 2/%h", which, data, exp);
    end
    checks++;
    if (bus_error !== 1'b1 || error_addr !== 32'h3000) begin
      failures++;
      $display("FAIL timeout2_err: err=%b addr=%h want 1/3000", bus_error, error_addr);
    end
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checks++;
    if (bus_error !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: got %b want 0", bus_error);
    end
    resp_lat = 2;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stores();
    int which, cyc, rc;
    logic [DW-1:0] data, exp;
    grant_t g;
    glog.delete();
    rc = req_cycles;
    exp_dmem_q.push_back(32'h0);
    dmem_addr = 32'h5000; dmem_write_data = 32'hCAFE_F00D;
    dmem_byte_enable = 4'h0; dmem_write = 1'b1;
    wait_any(10, which, data, cyc);
    dmem_write = 1'b0;
    exp = pop_exp(1'b1);
    // ready in the cycle right after the granting cycle
    checks++;
    if (which != 2 || cyc != 1 || data !== exp) begin
      failures++;
      $display("FAIL zstrobe_resp: which=%0d cyc=%0d data=%h want 2/1/%h", which, cyc, data, exp);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (req_cycles - rc != 0 || glog.size() != 0) begin
      failures++;
      $display("FAIL zstrobe_noreq: req_cycles=%0d issued=%0d want 0/0", req_cycles - rc, glog.size());
    end
    // read and write together: issued as a write with the given lanes
    exp_dmem_q.push_back(data_of(32'h5004));
    dmem_addr = 32'h5004; dmem_byte_enable = 4'h3;
    dmem_write = 1'b1; dmem_read = 1'b1;
    wait_any(20, which, data, cyc);
    dmem_write = 1'b0; dmem_read = 1'b0;
    exp = pop_exp(1'b1);
    checks++;
    if (which != 2 || data !== exp) begin
      failures++;
      $display("FAIL store_resp: which=%0d data=%h want 2/%h", which, data, exp);
    end
    repeat (2) @(negedge clk);
    g = (glog.size() > 0) ? glog.pop_front() : '0;
    checks++;
    if (g.addr !== 32'h5004 || g.we !== 1'b1 || g.be !== 4'h3 || g.wdata !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL store_bus: addr=%h we=%b be=%h wdata=%h want 5004/1/3/cafef00d",
               g.addr, g.we, g.be, g.wdata);
    end
  endtask

  task automatic test_reset_mid_access();
    int which, cyc, p_i, p_d;
    logic [DW-1:0] data, exp;
    resp_lat = 0;
    dmem_addr = 32'h6000; dmem_read = 1'b1;
    for (int i = 0; i < 5 && !mem_req; i++) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || grant_owner !== 2'd2 || mem_addr !== 32'h6000) begin
      failures++;
      $display("FAIL rst_busy: req=%b owner=%0d addr=%h want 1/2/6000", mem_req, grant_owner, mem_addr);
    end
    rst = 1'b1; dmem_read = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || grant_owner !== 2'd0) begin
      failures++;
      $display("FAIL rst_drop: req=%b owner=%0d want 0/0", mem_req, grant_owner);
    end
    rst = 1'b0;
    p_i = imem_pulses; p_d = dmem_pulses;
    @(negedge clk);
    tb_ack = 1'b1;
    @(negedge clk);
    tb_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_pulses != p_i || dmem_pulses != p_d) begin
      failures++;
      $display("FAIL rst_late_ack: pulses imem=%0d dmem=%0d want 0/0", imem_pulses - p_i, dmem_pulses - p_d);
    end
    resp_lat = 2;
    exp_imem_q.push_back(32'h0000_0013);
    imem_addr = 32'h100; imem_read = 1'b1;
    wait_any(20, which, data, cyc);
    imem_read = 1'b0;
    exp = pop_exp(1'b0);
    checks++;
    if (which != 1 || cyc != 4 || data !== exp) begin
      failures++;
      $display("FAIL rst_refetch: which=%0d cyc=%0d data=%h want 1/4/%h", which, cyc, data, exp);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lone_fetch();
    test_contention();
    test_starvation();
    test_timeout();
    test_stores();
    test_reset_mid_access();
    checks++;
    if (exp_imem_q.size() != 0 || exp_dmem_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: imem=%0d dmem=%0d left want 0/0",
               exp_imem_q.size(), exp_dmem_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timed out");
  end

endmodule
